// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, op encodings and mstatus bit positions
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [1:0] CSR_OP_N = 2'b00;
    localparam logic [1:0] CSR_OP_W = 2'b01;
    localparam logic [1:0] CSR_OP_S = 2'b10;
    localparam logic [1:0] CSR_OP_C = 2'b11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    function automatic logic csr_mapped(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: csr_mapped = 1'b1;
            default:                                          csr_mapped = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with independently writable 32-bit halves
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);

    // A write to either half suppresses the increment for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 64'd0;
        end else if (wr_lo) begin
            q[31:0] <= wdata;
        end else if (wr_hi) begin
            q[63:32] <= wdata;
        end else if (inc) begin
            q <= q + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode Zicsr register file with counters and trap/mret side effects
module csr_file
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter bit              CNT_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs1_zimm,
    input  logic            retire,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic [XLEN-1:0] rd_data,
    output logic            illegal,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            mie_out
);

    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [63:0]     mcycle_q;
    logic [63:0]     minstret_q;

    logic [1:0]      op;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] new_val;
    logic            active;
    logic            wr_intent;
    logic            read_only;
    logic            we;
    logic            csr_wr;

    assign op      = funct3[1:0];
    assign operand = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_zimm} : rs1_data;

    always_comb begin
        old_val = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                old_val[MSTATUS_MIE]  = mie_q;
                old_val[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MTVEC:                   old_val = mtvec_q;
            CSR_MSCRATCH:                old_val = mscratch_q;
            CSR_MEPC:                    old_val = mepc_q;
            CSR_MCAUSE:                  old_val = mcause_q;
            CSR_MCYCLE, CSR_CYCLE:       old_val = mcycle_q[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     old_val = mcycle_q[63:32];
            CSR_MINSTRET, CSR_INSTRET:   old_val = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret_q[63:32];
            default:                     old_val = '0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (op)
            CSR_OP_W: new_val = operand;
            CSR_OP_S: new_val = old_val | operand;
            CSR_OP_C: new_val = old_val & ~operand;
            default:  new_val = old_val;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it may target read-only CSRs.
    assign active    = csr_en && (op != CSR_OP_N);
    assign wr_intent = (op == CSR_OP_W) || (rs1_zimm != 5'd0);
    assign read_only = (csr_addr[11:10] == 2'b11);
    assign illegal   = active && (!csr_mapped(csr_addr) || (read_only && wr_intent));
    assign we        = active && !illegal && wr_intent;
    assign csr_wr    = we && !trap && !mret;
    assign rd_data   = illegal ? '0 : old_val;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (CNT_EN),
        .wr_lo (csr_wr && (csr_addr == CSR_MCYCLE)),
        .wr_hi (csr_wr && (csr_addr == CSR_MCYCLEH)),
        .wdata (new_val),
        .q     (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire && CNT_EN),
        .wr_lo (csr_wr && (csr_addr == CSR_MINSTRET)),
        .wr_hi (csr_wr && (csr_addr == CSR_MINSTRETH)),
        .wdata (new_val),
        .q     (minstret_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~{{(XLEN-2){1'b0}}, 2'b11};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap) begin
            mepc_q   <= trap_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
            mcause_q <= trap_cause;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (csr_wr) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[MSTATUS_MIE];
                    mpie_q <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= new_val & ~{{(XLEN-2){1'b0}}, 2'b11};
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & ~{{(XLEN-2){1'b0}}, 2'b11};
                CSR_MCAUSE:   mcause_q   <= new_val;
                default:      ;
            endcase
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed and randomized checks of csr_file against a behavioural model
module tb_csr_file;

    localparam logic [31:0] MTV_RST = 32'h0000_0103;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs1_zimm;
    logic        retire;
    logic        trap;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret;
    logic [31:0] rd_data;
    logic        illegal;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    csr_file #(.XLEN(32), .MTVEC_RESET(MTV_RST), .CNT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .csr_en(csr_en), .funct3(funct3), .csr_addr(csr_addr),
        .rs1_data(rs1_data), .rs1_zimm(rs1_zimm), .retire(retire), .trap(trap),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret), .rd_data(rd_data),
        .illegal(illegal), .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out)
    );

    always #5 clk = ~clk;

    // Reference state
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] last_rd;
    logic        last_ill;

    logic [11:0] addr_pool [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                    12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                    12'h7C0, 12'h301, 12'hF11};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = MTV_RST & 32'hFFFF_FFFC;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic is_mapped(input logic [11:0] a);
        foreach (addr_pool[i]) if (i < 13 && addr_pool[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic en, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] zimm, input logic ret,
                        input logic tr, input logic [31:0] cause, input logic [31:0] pc,
                        input logic mr);
        logic [1:0]  o;
        logic        wi, ill, cw;
        logic [31:0] old, bb, nv;
        logic [63:0] n_cyc, n_ins;
        csr_en = en; funct3 = f3; csr_addr = addr; rs1_data = rs1; rs1_zimm = zimm;
        retire = ret; trap = tr; trap_cause = cause; trap_pc = pc; mret = mr;
        #3;
        o   = f3[1:0];
        wi  = (o == 2'b01) || (zimm != 0);
        ill = en && (o != 0) && (!is_mapped(addr) || (addr[11:10] == 2'b11 && wi));
        old = mread(addr);
        chk("illegal", {31'b0, illegal}, {31'b0, ill});
        chk("rd_data", rd_data, ill ? 32'h0 : old);
        last_rd = rd_data; last_ill = illegal;
        bb = f3[2] ? {27'b0, zimm} : rs1;
        nv = (o == 2'b01) ? bb : (o == 2'b10) ? (old | bb) : (old & ~bb);
        cw = en && (o != 0) && !ill && wi && !tr && !mr;
        n_cyc = m_cyc + 1;
        if (cw && addr == 12'hB00) n_cyc = {m_cyc[63:32], nv};
        if (cw && addr == 12'hB80) n_cyc = {nv, m_cyc[31:0]};
        n_ins = m_ins + (ret ? 64'd1 : 64'd0);
        if (cw && addr == 12'hB02) n_ins = {m_ins[63:32], nv};
        if (cw && addr == 12'hB82) n_ins = {nv, m_ins[31:0]};
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_cyc = n_cyc; m_ins = n_ins;
            if (tr) begin
                m_mepc = pc & 32'hFFFF_FFFC; m_mcause = cause;
                m_mpie = m_mie; m_mie = 0;
            end else if (mr) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (cw) begin
                case (addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & 32'hFFFF_FFFC;
                    12'h342: m_mcause = nv;
                    default: ;
                endcase
            end
        end
        #1;
        chk("mtvec_out", mtvec_out, m_mtvec);
        chk("mepc_out", mepc_out, m_mepc);
        chk("mie_out", {31'b0, mie_out}, {31'b0, m_mie});
    endtask

    task automatic op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                      input logic [4:0] zimm);
        step(1'b1, f3, addr, rs1, zimm, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic [4:0] z;
            z = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 7) != 0, 3'($urandom), addr_pool[$urandom_range(0, 15)],
                 $urandom, z, 1'($urandom), $urandom_range(0, 15) == 0, $urandom, $urandom,
                 $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        rst = 1;
        csr_en = 0; funct3 = 0; csr_addr = 0; rs1_data = 0; rs1_zimm = 0;
        retire = 0; trap = 0; trap_cause = 0; trap_pc = 0; mret = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        chk("reset_mtvec", mtvec_out, 32'h0000_0100);
        chk("reset_mepc", mepc_out, 32'h0);
        chk("reset_mie", {31'b0, mie_out}, 32'h0);

        // mscratch write then read-only set with x0
        op(3'b001, 12'h340, 32'hDEADBEEF, 5'd5);
        chk("mscratch_old", last_rd, 32'h0);
        op(3'b010, 12'h340, 32'h0000_FFFF, 5'd0);
        chk("mscratch_rd", last_rd, 32'hDEADBEEF);
        op(3'b010, 12'h340, 32'h0, 5'd0);
        chk("mscratch_nowr", last_rd, 32'hDEADBEEF);

        // mstatus immediates and field masking
        op(3'b110, 12'h300, 32'h0, 5'd8);
        op(3'b010, 12'h300, 32'h0, 5'd0);
        chk("mstatus_si", last_rd, 32'h8);
        op(3'b111, 12'h300, 32'h0, 5'd8);
        op(3'b010, 12'h300, 32'h0, 5'd0);
        chk("mstatus_ci", last_rd, 32'h0);
        op(3'b001, 12'h300, 32'hFFFF_FFFF, 5'd1);
        op(3'b010, 12'h300, 32'h0, 5'd0);
        chk("mstatus_mask", last_rd, 32'h88);
        op(3'b001, 12'h300, 32'h0, 5'd1);

        // illegal accesses
        op(3'b001, 12'hC00, 32'h5, 5'd1);
        chk("ro_write_ill", {31'b0, last_ill}, 32'h1);
        chk("ro_write_rd", last_rd, 32'h0);
        op(3'b010, 12'hC00, 32'h5, 5'd0);
        chk("ro_read_ill", {31'b0, last_ill}, 32'h0);
        op(3'b010, 12'h7C0, 32'h0, 5'd0);
        chk("unmapped_ill", {31'b0, last_ill}, 32'h1);
        chk("unmapped_rd", last_rd, 32'h0);

        // mcycle wrap into high half
        op(3'b001, 12'hB80, 32'h0, 5'd1);
        op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1);
        op(3'b010, 12'hB00, 32'h0, 5'd0);
        chk("mcycle_hold", last_rd, 32'hFFFF_FFFF);
        op(3'b010, 12'hB00, 32'h0, 5'd0);
        chk("mcycle_wrap", last_rd, 32'h0);
        op(3'b010, 12'hB80, 32'h0, 5'd0);
        chk("mcycleh_carry", last_rd, 32'h1);

        // minstret counts retire pulses only
        op(3'b001, 12'hB02, 32'h0, 5'd1);
        op(3'b001, 12'hB82, 32'h0, 5'd1);
        for (int i = 0; i < 7; i++)
            step(1'b0, 3'b0, 12'h0, 32'h0, 5'd0, (i != 2 && i != 5), 1'b0, 32'h0, 32'h0, 1'b0);
        op(3'b010, 12'hB02, 32'h0, 5'd0);
        chk("minstret_5", last_rd, 32'd5);

        // trap, mret, and a CSR write dropped by a trap
        op(3'b110, 12'h300, 32'h0, 5'd8);
        step(1'b0, 3'b0, 12'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hB, 32'h0000_1003, 1'b0);
        chk("trap_mepc", mepc_out, 32'h0000_1000);
        op(3'b010, 12'h342, 32'h0, 5'd0);
        chk("trap_mcause", last_rd, 32'hB);
        op(3'b010, 12'h300, 32'h0, 5'd0);
        chk("trap_mstatus", last_rd, 32'h80);
        step(1'b0, 3'b0, 12'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        op(3'b010, 12'h300, 32'h0, 5'd0);
        chk("mret_mstatus", last_rd, 32'h88);
        step(1'b1, 3'b001, 12'h340, 32'h1234_5678, 5'd1, 1'b0, 1'b1, 32'h7, 32'h2000, 1'b0);
        chk("trap_wr_rd", last_rd, 32'hDEADBEEF);
        op(3'b010, 12'h340, 32'h0, 5'd0);
        chk("trap_wr_drop", last_rd, 32'hDEADBEEF);

        random_steps(400);

        // reset in the middle of activity
        rst = 1;
        op(3'b001, 12'h340, 32'hCAFE_F00D, 5'd1);
        rst = 0;
        op(3'b010, 12'hB00, 32'h0, 5'd0);
        chk("rst_mcycle", last_rd, 32'h0);
        op(3'b010, 12'h305, 32'h0, 5'd0);
        chk("rst_mtvec", last_rd, 32'h0000_0100);
        op(3'b010, 12'h340, 32'h0, 5'd0);
        chk("rst_mscratch", last_rd, 32'h0);
        op(3'b010, 12'h300, 32'h0, 5'd0);
        chk("rst_mstatus", last_rd, 32'h0);

        random_steps(200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the single-cycle RV32 core.
- Holds the CSR state and performs the Zicsr read-modify-write ops (CSRRW/RS/RC and immediate forms).
- Adds legality checking, 64-bit cycle/instret counters, and trap-entry/MRET side effects.
- Sits beside the register file. Read is combinational in the same cycle; the write commits at the clock edge.

Parameters:
- XLEN, 32, data width of rs1_data/rd_data; only 32 is supported.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits[1:0] forced 0).
- CNT_EN, 1, when 0 the counters hold (no auto-increment) but stay readable/writable.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- csr_en  in  1  instruction is SYSTEM/CSR this cycle
- funct3  in  3  [2]=immediate form, [1:0]: 01 write, 10 set, 11 clear, 00 no-op
- csr_addr  in  12  CSR address
- rs1_data  in  32  register operand
- rs1_zimm  in  5  rs1 index, or zimm in the immediate form
- retire  in  1  an instruction retires this cycle
- trap  in  1  trap entry this cycle
- trap_cause  in  32  value for mcause
- trap_pc  in  32  faulting PC
- mret  in  1  MRET executing this cycle
- rd_data  out  32  old CSR value
- illegal  out  1  illegal CSR access (combinational)
- mtvec_out  out  32  trap vector
- mepc_out  out  32  return PC
- mie_out  out  1  mstatus.MIE

Behaviour:
- Reset (rst=1 at posedge):
  - All CSRs are 0, except mtvec=MTVEC_RESET & ~3.
  - Combinational outputs then follow: rd_data=0 when the address is unmapped, illegal=0 when csr_en=0.
- Implemented map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are stored; all other bits read 0.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341.
  - mcause 0x342.
  - mcycle 0xB00 / mcycleh 0xB80.
  - minstret 0xB02 / minstreth 0xB82.
  - Read-only shadows: cycle 0xC00 / cycleh 0xC80, instret 0xC02 / instreth 0xC82.
- Operand: b = funct3[2] ? {27'b0, rs1_zimm} : rs1_data.
- New value:
  - 01: b
  - 10: old | b
  - 11: old & ~b
- Write enable (we): csr_en & legal & (funct3[1:0]==01 | rs1_zimm!=0). Set/clear with x0/zimm=0 performs the read only.
- illegal is asserted when csr_en & funct3[1:0]!=0 and either:
  - the address is unmapped, or
  - addr[11:10]==2'b11 and we would be asserted.
- When illegal: no state change, rd_data=0.
- rd_data returns the value before this cycle's update, including counters before their increment.
- Field masking:
  - mtvec and mepc writes force bits[1:0]=0.
  - mstatus writes update only bits 3 and 7.
- Counters:
  - mcycle(64) increments by 1 every cycle when CNT_EN.
  - minstret(64) increments when retire & CNT_EN.
  - The low half carries into the high half on wrap (0xFFFF_FFFF -> high+1, low=0).
  - Explicit write to either half that cycle: the written half takes the written value, the other half holds. There is no increment that cycle for that counter.
- Side-effect priority per cycle: trap > mret > CSR write. A CSR write in the same cycle as trap or mret is dropped; rd_data is still valid.
- Trap:
  - mepc <= trap_pc & ~3
  - mcause <= trap_cause
  - MPIE <= MIE
  - MIE <= 0
- Mret:
  - MIE <= MPIE
  - MPIE <= 1
- Reset mid-operation overrides all of the above.
- Outputs mtvec_out, mepc_out and mie_out are driven directly from the registers.

Decomposition:
- Shared package csr_pkg:
  - CSR address localparams (CSR_MSTATUS, CSR_MTVEC, ... CSR_INSTRETH).
  - funct3 op encodings (CSR_OP_W=2'b01, CSR_OP_S=2'b10, CSR_OP_C=2'b11).
  - mstatus bit indices MIE=3, MPIE=7.
- One sub-module: csr_counter64 (clk, rst, inc, wr_lo, wr_hi, wdata, q[63:0]), instantiated twice, for mcycle and minstret.

Test Plan:
- Write/read mscratch:
  - CSRRW 0x340 rs1_data=0xDEADBEEF -> rd_data=0.
  - Next cycle CSRRS x0 -> rd_data=0xDEADBEEF, no write.
- Set/clear immediates on mstatus:
  - CSRRSI 0x300 zimm=8 -> MIE=1.
  - CSRRCI zimm=8 -> MIE=0.
  - CSRRW 0x300 with 0xFFFFFFFF -> read back 0x00000088.
- Illegal accesses:
  - CSRRW 0xC00 -> illegal=1, cycle unchanged.
  - CSRRS 0xC00 x0 -> illegal=0, rd_data=cycle.
  - Access 0x7C0 -> illegal=1, rd_data=0.
- Counter wrap:
  - Write mcycle=0xFFFFFFFF, mcycleh=0.
  - Two cycles later mcycleh=1, mcycle=0x00000000 (write cycle does not increment).
  - minstret counts only retire pulses (5 pulses -> 5).
- Trap then mret:
  - Start MIE=1; trap with trap_pc=0x0000_1003, cause=0xB -> mepc=0x1000, mcause=0xB, MIE=0, MPIE=1.
  - mret -> MIE=1, MPIE=1.
  - Trap with a simultaneous CSRRW mscratch -> mscratch unchanged.
- Reset:
  - rst asserted mid-sequence -> all CSRs 0, mtvec=MTVEC_RESET & ~3, counters restart from 0 the cycle after rst drops.
